scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 135 +++++++++++++
 tb/tb_scan_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select through up, down, ping-pong
// or single-shot patterns, holding each select value for DIV clock cycles.
module scan_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic       En,
  output logic       busy,
  output logic       wrap
);

  localparam int unsigned PW = 4;
  localparam int unsigned SW = 3;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir, dir_d;        // 0 = counting up, 1 = counting down (ping-pong only)
  logic [SW-1:0] sel_d;
  logic          en_d, busy_d, wrap_d;
  logic          step_c;

  // Prescaler terminal count: a select step happens on this cycle
  assign step_c = (pcnt == PW'(DIV - 1));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      mode_q <= MODE_UP;
      dir    <= 1'b0;
      sel    <= '0;
      En     <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_d;
      pcnt   <= pcnt_d;
      mode_q <= mode_d;
      dir    <= dir_d;
      sel    <= sel_d;
      En     <= en_d;
      busy   <= busy_d;
      wrap   <= wrap_d;
    end
  end

  // Next-state, select stepping and wrap generation
  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    mode_d  = mode_q;
    dir_d   = dir;
    sel_d   = sel;
    wrap_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          pcnt_d  = '0;
          dir_d   = 1'b0;
          sel_d   = (mode == MODE_DOWN) ? SW'(7) : SW'(0);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pcnt_d  = '0;
        end else if (step_c) begin
          pcnt_d = '0;
          case (mode_q)
            MODE_UP: begin
              sel_d  = sel + SW'(1);
              wrap_d = (sel == SW'(7));
            end
            MODE_DOWN: begin
              sel_d  = sel - SW'(1);
              wrap_d = (sel == SW'(0));
            end
            MODE_PP: begin
              if (!dir) begin
                if (sel == SW'(7)) begin
                  dir_d = 1'b1;
                  sel_d = SW'(6);
                end else begin
                  sel_d = sel + SW'(1);
                end
              end else begin
                if (sel == SW'(0)) begin
                  dir_d = 1'b0;
                  sel_d = SW'(1);
                end else begin
                  sel_d  = sel - SW'(1);
                  wrap_d = (sel == SW'(1));
                end
              end
            end
            MODE_ONE: begin
              if (sel == SW'(7)) begin
                state_d = IDLE;
                sel_d   = '0;
                wrap_d  = 1'b1;
              end else begin
                sel_d = sel + SW'(1);
              end
            end
            default: sel_d = sel;
          endcase
        end else begin
          pcnt_d = pcnt + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    en_d   = busy_d;
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer: several DIV instances share one
// stimulus stream and are checked against a step-index reference model.
module tb_scan_sequencer;

  localparam int NI = 5;
  localparam int DIVS [NI] = '{1, 2, 3, 4, 16};

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [1:0] mode;

  logic [NI-1:0][2:0] sel_o;
  logic [NI-1:0]      en_o, busy_o, wrap_o;

  int vectors = 0;
  int errors  = 0;

  // Reference model: position k counts completed steps since start,
  // c counts cycles spent on the current step.
  int run   [NI];
  int m     [NI];
  int k     [NI];
  int c     [NI];
  int msel  [NI];
  int mwrap [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scan_sequencer #(.DIV(DIVS[g])) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .sel   (sel_o[g]),
      .En    (en_o[g]),
      .busy  (busy_o[g]),
      .wrap  (wrap_o[g])
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Select value at step position kk of the pattern for mode mm
  function automatic int sel_of(input int mm, input int kk);
    int p;
    case (mm)
      0: return kk % 8;
      1: return 7 - (kk % 8);
      2: begin
        p = kk % 14;
        return (p <= 7) ? p : 14 - p;
      end
      default: return kk;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      run[i] = 0; m[i] = 0; k[i] = 0; c[i] = 0; msel[i] = 0; mwrap[i] = 0;
    end
  endfunction

  // One rising edge of the model using the inputs present at that edge
  function automatic void model_step(input int i);
    mwrap[i] = 0;
    if (run[i] == 0) begin
      if (start && !stop) begin
        run[i] = 1; m[i] = int'(mode); k[i] = 0; c[i] = 0;
        msel[i] = sel_of(m[i], 0);
      end
    end else if (stop) begin
      run[i] = 0;
    end else if (c[i] == DIVS[i] - 1) begin
      c[i] = 0;
      k[i]++;
      if (m[i] == 3 && k[i] == 8) begin
        run[i] = 0; msel[i] = 0; mwrap[i] = 1;
      end else begin
        msel[i] = sel_of(m[i], k[i]);
        if (m[i] < 2)  mwrap[i] = (k[i] % 8 == 0)  ? 1 : 0;
        if (m[i] == 2) mwrap[i] = (k[i] % 14 == 0) ? 1 : 0;
      end
    end else begin
      c[i]++;
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("sel[div=%0d]", DIVS[i]),  int'(sel_o[i]),  msel[i]);
      check($sformatf("En[div=%0d]", DIVS[i]),   int'(en_o[i]),   run[i]);
      check($sformatf("busy[div=%0d]", DIVS[i]), int'(busy_o[i]), run[i]);
      check($sformatf("wrap[div=%0d]", DIVS[i]), int'(wrap_o[i]), mwrap[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    for (int j = 0; j < n; j++) cycle();
  endtask

  task automatic pulse_start(input logic [1:0] md);
    mode = md; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Reset pulse placed between clock edges
  task automatic async_rst();
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    model_reset();
    #3 check_all();
    #9 rst = 1'b0;

    run_cycles(2);
    pulse_start(2'b00); run_cycles(40);
    stop = 1'b1; cycle(); stop = 1'b0;

    pulse_start(2'b10); run_cycles(10);
    mode = 2'b01; run_cycles(25);
    stop = 1'b1; cycle(); stop = 1'b0;

    pulse_start(2'b11); run_cycles(30);
    start = 1'b1; stop = 1'b1; run_cycles(5);
    start = 1'b0; stop = 1'b0; run_cycles(3);

    pulse_start(2'b01); run_cycles(10);
    stop = 1'b1; cycle();
    start = 1'b1; run_cycles(3);
    start = 1'b0; stop = 1'b0;

    pulse_start(2'b00); run_cycles(12);
    async_rst(); run_cycles(5);

    pulse_start(2'b11); run_cycles(140);
    pulse_start(2'b10); run_cycles(60);
    stop = 1'b1; cycle(); stop = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      start = ($urandom % 8) == 0;
      stop  = ($urandom % 64) == 0;
      mode  = 2'($urandom);
      cycle();
      if (($urandom % 200) == 0) async_rst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
